dphy_tx_lane: RTL and testbench
===============================

// Module: dphy_tx_lane
// PURPOSE
//  Single-lane MIPI D-PHY high-speed transmitter, the transmit-side counterpart of the D-PHY receive path.
//  Accepts bytes over a PPI-style request/ready handshake and sequences one HS burst:
//  LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync byte -> payload -> HS-trail -> LP-11.
//  Serializes one bit per clk_i cycle, LSB first, and sits between the CSI-2 packetizer and the lane pad drivers.
// PARAMETERS
//  T_LPX        4     cycles in LP-01 (TLPX)
//  T_HS_PREPARE 6     cycles in LP-00 before HS drive (THS-PREPARE)
//  T_HS_ZERO    16    cycles of HS-0 before sync (THS-ZERO); must be >=1
//  T_HS_TRAIL   8     cycles of HS trail (THS-TRAIL); must be >=1
// PORTS
//  clk_i            in   1  bit clock; one serial bit per cycle
//  reset_n_i        in   1  synchronous active-low reset
//  tx_request_i     in   1  PPI TxRequestHS; high = burst wanted / more bytes available
//  tx_data_i        in   8  PPI TxDataHS; must be valid whenever tx_request_i is high
//  tx_ready_o       out  1  PPI TxReadyHS; one-cycle pulse = tx_data_i consumed this cycle
//  stop_state_o     out  1  high while lane is in LP-11 idle
//  lp_p_o, lp_n_o   out  1  low-power single-ended line levels
//  hs_en_o          out  1  enables HS differential driver
//  hs_data_o        out  1  serial HS bit to driver
// BEHAVIOUR
//  Reset (reset_n_i low at a clk_i edge): state IDLE; lp_p_o=1, lp_n_o=1, hs_en_o=0, hs_data_o=0,
//   tx_ready_o=0, stop_state_o=1; all counters and shift register cleared. Takes effect mid-burst,
//   including during HS: next cycle the lane is LP-11 with hs_en_o=0.
//  States and outputs (lp_p/lp_n, hs_en):
//   IDLE 1/1,0 -> LPX when tx_request_i=1 is sampled (enter next cycle).
//   LPX 0/1,0 for T_LPX cycles -> PREP.   PREP 0/0,0 for T_HS_PREPARE cycles -> ZERO.
//   ZERO 0/0,1, hs_data_o=0 for T_HS_ZERO cycles -> SYNC.
//   SYNC 0/0,1, shifts 8'hB8 LSB first (0,0,0,1,1,1,0,1) over 8 cycles.
//   DATA 0/0,1, shifts the accepted byte LSB first over 8 cycles.
//   TRAIL 0/0,1, hs_data_o = inverse of last transmitted bit for T_HS_TRAIL cycles.
//   EXIT: one cycle with hs_en_o=0 and LP-11 -> IDLE (stop_state_o=1 from the IDLE cycle on).
//  Byte boundary: the cycle the 8th bit (index 7) of SYNC or DATA is on hs_data_o.
//   If tx_request_i=1: tx_ready_o=1 that cycle, tx_data_i loaded into shift reg, bit0 driven next cycle
//   (no bubble between bytes) -> DATA. If tx_request_i=0: tx_ready_o=0 -> TRAIL next cycle.
//  tx_request_i is ignored outside IDLE and byte boundaries; dropping it during LPX..SYNC does not
//   abort the burst and yields an empty burst (sync + trail).
//  tx_ready_o is never asserted outside a byte boundary; at most one pulse per 8 cycles.
//  Latency: request sampled in IDLE at cycle 0 -> LPX at cycle 1; first payload bit at cycle
//   1+T_LPX+T_HS_PREPARE+T_HS_ZERO+8; first tx_ready_o at cycle T_LPX+T_HS_PREPARE+T_HS_ZERO+8.
//  Counters: one shared down-counter sized $clog2(max timing param)+1; 3-bit bit index wraps 7->0.
//  A new burst requires passing through EXIT and IDLE (at least 2 cycles of LP-11 with
//   hs_en_o=0 before LPX); tx_request_i held high through TRAIL starts the next burst from IDLE.
// STRUCTURE
//  dphy_pkg: dphy_tx_state_e enum (IDLE,LPX,PREP,ZERO,SYNC,DATA,TRAIL,EXIT), DPHY_SYNC_BYTE=8'hB8,
//   LP-state encodings shared with the receive path.
//  Sub-module dphy_tx_shift: 8-bit LSB-first shift register + 3-bit bit index, load/shift controls,
//   last_bit flag. FSM and timing counter stay in this module.
// TESTING
//  1. Reset: hold reset_n_i low 3 cycles with tx_request_i=1 -> LP-11, hs_en_o=0, tx_ready_o=0, stop_state_o=1.
//  2. One byte 8'h5A, defaults: LP-01 4 cyc, LP-00 6 cyc, 16 zeros, bits 0,0,0,1,1,1,0,1,
//     then 0,1,0,1,1,0,1,0, tx_ready_o at cycle 34 only, trail=1 for 8 cyc, LP-11.
//  3. Back-to-back 8'h00,8'hFF,8'hA5 with request held: 3 ready pulses 8 cycles apart,
//     24 contiguous payload bits, trail=0 (last bit 1).
//  4. Request pulsed one cycle in IDLE: empty burst; sync 8'hB8 then trail=0, zero tx_ready_o pulses.
//  5. Reset asserted mid-DATA (bit 3 of byte 2): next cycle LP-11, hs_en_o=0; new request restarts at LPX.
//  6. Request held high across burst end: EXIT + IDLE cycles at LP-11, then LPX; T_HS_ZERO=1 variant passes.

Source files
------------

// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions: transmit FSM states, sync byte, LP line encodings
// and the line-level decode used by the transmit lane.
package dphy_pkg;

  localparam int unsigned DPHY_BYTE_W    = 8;
  localparam int unsigned DPHY_BIT_IDX_W = 3;

  localparam logic [DPHY_BYTE_W-1:0] DPHY_SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    LPX,
    PREP,
    ZERO,
    SYNC,
    DATA,
    TRAIL,
    EXIT
  } dphy_tx_state_e;

  // Low-power line states, encoded as {lp_p, lp_n}; shared with the receive path.
  typedef enum logic [1:0] {
    LP_00 = 2'b00,
    LP_01 = 2'b01,
    LP_10 = 2'b10,
    LP_11 = 2'b11
  } dphy_lp_state_e;

  typedef struct packed {
    dphy_lp_state_e lp;
    logic           hs_en;
  } dphy_line_t;

  // Line levels driven while the transmitter sits in a given state.
  function automatic dphy_line_t dphy_tx_line(input dphy_tx_state_e st);
    dphy_line_t l;
    l.lp    = LP_00;
    l.hs_en = 1'b0;
    case (st)
      IDLE, EXIT: l.lp = LP_11;
      LPX:        l.lp = LP_01;
      PREP:       l.lp = LP_00;
      default: begin
        l.lp    = LP_00;
        l.hs_en = 1'b1;
      end
    endcase
    return l;
  endfunction

  function automatic int unsigned dphy_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dphy_tx_shift.sv
// LSB-first byte serializer with bit index.
// Ports:
//   clk_i, reset_n_i  clock, synchronous active-low reset
//   load_i            load load_data_i, restart bit index at 0 (highest priority)
//   clear_i           zero shift register and bit index
//   shift_i           shift right by one bit, advance bit index (wraps 7->0)
//   load_data_i       byte to serialize
//   bit_o             bit currently presented on the line (register bit 0)
//   last_bit_o        bit index 7 is on the line (byte boundary)
module dphy_tx_shift
  import dphy_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic [DPHY_BYTE_W-1:0] load_data_i,
  output logic                   bit_o,
  output logic                   last_bit_o
);

  logic [DPHY_BYTE_W-1:0]    sreg_q;
  logic [DPHY_BIT_IDX_W-1:0] idx_q;

  // Shift register and bit index.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      sreg_q <= load_data_i;
      idx_q  <= '0;
    end else if (clear_i) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (shift_i) begin
      sreg_q <= {1'b0, sreg_q[DPHY_BYTE_W-1:1]};
      idx_q  <= idx_q + DPHY_BIT_IDX_W'(1);
    end
  end

  assign bit_o      = sreg_q[0];
  assign last_bit_o = (idx_q == DPHY_BIT_IDX_W'(DPHY_BYTE_W - 1));

endmodule

// File: rtl/dphy_tx_lane.sv
// Single-lane D-PHY HS transmitter: sequences LP-11 -> LP-01 -> LP-00 ->
// HS-zero -> sync -> payload -> HS-trail -> LP-11, one serial bit per clock.
// Ports:
//   clk_i         bit clock
//   reset_n_i     synchronous active-low reset
//   tx_request_i  burst wanted / next byte available
//   tx_data_i     byte offered while tx_request_i is high
//   tx_ready_o    byte consumed this cycle (combinational on tx_request_i)
//   stop_state_o  lane idle in LP-11
//   lp_p_o/lp_n_o low-power line levels
//   hs_en_o       HS driver enable
//   hs_data_o     serial HS bit
// T_LPX and T_HS_PREPARE are assumed >= 1 like the other timing parameters.
module dphy_tx_lane
  import dphy_pkg::*;
#(
  parameter int unsigned T_LPX        = 4,
  parameter int unsigned T_HS_PREPARE = 6,
  parameter int unsigned T_HS_ZERO    = 16,
  parameter int unsigned T_HS_TRAIL   = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   tx_request_i,
  input  logic [DPHY_BYTE_W-1:0] tx_data_i,
  output logic                   tx_ready_o,
  output logic                   stop_state_o,
  output logic                   lp_p_o,
  output logic                   lp_n_o,
  output logic                   hs_en_o,
  output logic                   hs_data_o
);

  localparam int unsigned T_MAX = dphy_max(dphy_max(T_LPX, T_HS_PREPARE),
                                           dphy_max(T_HS_ZERO, T_HS_TRAIL));
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] LPX_LOAD   = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] PREP_LOAD  = CNT_W'(T_HS_PREPARE - 1);
  localparam logic [CNT_W-1:0] ZERO_LOAD  = CNT_W'(T_HS_ZERO - 1);
  localparam logic [CNT_W-1:0] TRAIL_LOAD = CNT_W'(T_HS_TRAIL - 1);

  dphy_tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   cnt_done;

  logic                   sh_load, sh_clear, sh_shift;
  logic [DPHY_BYTE_W-1:0] sh_data;
  logic                   sh_bit, sh_last;

  dphy_line_t             line_d;
  logic [1:0]             lp_d;
  logic                   stop_d;

  dphy_tx_shift u_shift (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_i      (sh_load),
    .clear_i     (sh_clear),
    .shift_i     (sh_shift),
    .load_data_i (sh_data),
    .bit_o       (sh_bit),
    .last_bit_o  (sh_last)
  );

  assign cnt_done  = (cnt_q == '0);
  assign hs_data_o = sh_bit;

  // A byte is taken only on the last bit of SYNC/DATA; held off while in reset.
  assign tx_ready_o = reset_n_i && tx_request_i && sh_last &&
                      ((state_q == SYNC) || (state_q == DATA));

  // Next-state, timing counter and serializer control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_clear = 1'b0;
    sh_shift = 1'b0;
    sh_data  = DPHY_SYNC_BYTE;
    unique case (state_q)
      IDLE: begin
        sh_clear = 1'b1;
        if (tx_request_i) begin
          state_d = LPX;
          cnt_d   = LPX_LOAD;
        end
      end
      LPX: begin
        sh_clear = 1'b1;
        if (cnt_done) begin
          state_d = PREP;
          cnt_d   = PREP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PREP: begin
        sh_clear = 1'b1;
        if (cnt_done) begin
          state_d = ZERO;
          cnt_d   = ZERO_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ZERO: begin
        if (cnt_done) begin
          state_d = SYNC;
          sh_load = 1'b1;
        end else begin
          sh_clear = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      SYNC, DATA: begin
        if (sh_last) begin
          sh_load = 1'b1;
          if (tx_request_i) begin
            state_d = DATA;
            sh_data = tx_data_i;
          end else begin
            // Trail holds the inverse of the last payload bit for its whole length.
            state_d = TRAIL;
            cnt_d   = TRAIL_LOAD;
            sh_data = {DPHY_BYTE_W{~sh_bit}};
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      TRAIL: begin
        if (cnt_done) begin
          state_d  = EXIT;
          sh_clear = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXIT: begin
        state_d  = IDLE;
        sh_clear = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        sh_clear = 1'b1;
      end
    endcase
    line_d = dphy_tx_line(state_d);
    lp_d   = line_d.lp;
    stop_d = (state_d == IDLE);
  end

  // State, counter and registered line outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lp_p_o       <= 1'b1;
      lp_n_o       <= 1'b1;
      hs_en_o      <= 1'b0;
      stop_state_o <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lp_p_o       <= lp_d[1];
      lp_n_o       <= lp_d[0];
      hs_en_o      <= line_d.hs_en;
      stop_state_o <= stop_d;
    end
  end

endmodule

// File: tb/tb_dphy_tx_lane.sv
// Directed bench for dphy_tx_lane: checks the line every cycle of each burst.
// Observed vector: {lp_p, lp_n, hs_en, hs_data, tx_ready, stop_state}.
module tb_dphy_tx_lane;

  logic       clk;
  logic       reset_n;
  logic       tx_request;
  logic [7:0] tx_data;

  logic rdy0, stop0, lpp0, lpn0, hse0, hsd0;
  logic rdy1, stop1, lpp1, lpn1, hse1, hsd1;

  int   tests;
  int   fails;
  int   sel;
  logic [7:0] pay [0:3];

  localparam logic [5:0] IDLE_V = 6'b110001;
  localparam logic [5:0] LPX_V  = 6'b010000;
  localparam logic [5:0] PREP_V = 6'b000000;
  localparam logic [5:0] ZERO_V = 6'b001000;
  localparam logic [5:0] EXIT_V = 6'b110000;

  dphy_tx_lane dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .tx_request_i (tx_request),
    .tx_data_i    (tx_data),
    .tx_ready_o   (rdy0),
    .stop_state_o (stop0),
    .lp_p_o       (lpp0),
    .lp_n_o       (lpn0),
    .hs_en_o      (hse0),
    .hs_data_o    (hsd0)
  );

  dphy_tx_lane #(.T_HS_ZERO(1)) dut_z1 (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .tx_request_i (tx_request),
    .tx_data_i    (tx_data),
    .tx_ready_o   (rdy1),
    .stop_state_o (stop1),
    .lp_p_o       (lpp1),
    .lp_n_o       (lpn1),
    .hs_en_o      (hse1),
    .hs_data_o    (hsd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    if (sel == 1) return {lpp1, lpn1, hse1, hsd1, rdy1, stop1};
    return {lpp0, lpn0, hse0, hsd0, rdy0, stop0};
  endfunction

  // Drive one cycle's inputs just after the edge; return at the sampling point.
  task automatic cyc(input logic rst, input logic req, input logic [7:0] d);
    @(posedge clk);
    #1;
    reset_n    = rst;
    tx_request = req;
    tx_data    = d;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] o;
    o = obs();
    tests++;
    assert (o === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // One burst of n bytes from pay[], started from IDLE. hold keeps the request
  // high through trail/exit; (ab_k, ab_j) asserts reset on that payload bit.
  task automatic burst(input string tag, input int n, input logic hold,
                       input int lpx, input int prep, input int zero, input int trail,
                       input int ab_k, input int ab_j);
    logic       req_run;
    logic       more;
    logic       last;
    logic       rst;
    logic [7:0] sb;
    logic [7:0] cur;
    logic [7:0] nd;
    sb      = 8'hB8;
    req_run = (n > 0);
    cyc(1'b1, 1'b1, pay[0]);
    chk({tag, "_idle"}, IDLE_V);
    for (int i = 0; i < lpx; i++) begin
      cyc(1'b1, req_run, pay[0]);
      chk({tag, "_lpx"}, LPX_V);
    end
    for (int i = 0; i < prep; i++) begin
      cyc(1'b1, req_run, pay[0]);
      chk({tag, "_prep"}, PREP_V);
    end
    for (int i = 0; i < zero; i++) begin
      cyc(1'b1, req_run, pay[0]);
      chk({tag, "_zero"}, ZERO_V);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, req_run, pay[0]);
      chk({tag, "_sync"}, {3'b001, sb[i], (i == 7) && req_run, 1'b0});
    end
    last = sb[7];
    for (int k = 0; k < n; k++) begin
      more = (k + 1 < n);
      nd   = more ? pay[k+1] : 8'h00;
      cur  = pay[k];
      for (int j = 0; j < 8; j++) begin
        rst = !((k == ab_k) && (j == ab_j));
        cyc(rst, more, nd);
        chk({tag, "_data"}, {3'b001, cur[j], (j == 7) && more, 1'b0});
        if (!rst) return;
        last = cur[j];
      end
    end
    for (int i = 0; i < trail; i++) begin
      cyc(1'b1, hold, pay[0]);
      chk({tag, "_trail"}, {3'b001, ~last, 2'b00});
    end
    cyc(1'b1, hold, pay[0]);
    chk({tag, "_exit"}, EXIT_V);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    sel        = 0;
    reset_n    = 1'b0;
    tx_request = 1'b1;
    tx_data    = 8'h00;
    pay[0] = 8'h00; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;

    // Reset held with a pending request.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("reset", IDLE_V);
    end
    cyc(1'b1, 1'b0, 8'h00);
    chk("reset_release", IDLE_V);

    // Single byte 0x5A.
    pay[0] = 8'h5A;
    burst("one", 1, 1'b0, 4, 6, 16, 8, -1, -1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("one_after", IDLE_V);

    // Back-to-back bytes.
    pay[0] = 8'h00; pay[1] = 8'hFF; pay[2] = 8'hA5;
    burst("b2b", 3, 1'b0, 4, 6, 16, 8, -1, -1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("b2b_after", IDLE_V);

    // One-cycle request pulse: empty burst.
    pay[0] = 8'h77;
    burst("empty", 0, 1'b0, 4, 6, 16, 8, -1, -1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("empty_after", IDLE_V);

    // Reset on bit 3 of the second byte, then a fresh burst.
    pay[0] = 8'h11; pay[1] = 8'h2A; pay[2] = 8'h33;
    burst("abort", 3, 1'b0, 4, 6, 16, 8, 1, 3);
    cyc(1'b1, 1'b0, 8'h00);
    chk("abort_lp11", IDLE_V);
    pay[0] = 8'h96;
    burst("restart", 1, 1'b0, 4, 6, 16, 8, -1, -1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("restart_after", IDLE_V);

    // Request held across burst end: EXIT and IDLE before the next LPX.
    pay[0] = 8'h3C;
    burst("hold1", 1, 1'b1, 4, 6, 16, 8, -1, -1);
    pay[0] = 8'hC3;
    burst("hold2", 1, 1'b0, 4, 6, 16, 8, -1, -1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("hold_after", IDLE_V);

    // Minimum HS-zero instance.
    sel = 1;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("z1_reset", IDLE_V);
    cyc(1'b1, 1'b0, 8'h00);
    chk("z1_idle", IDLE_V);
    pay[0] = 8'hE1;
    burst("z1a", 1, 1'b1, 4, 6, 1, 8, -1, -1);
    pay[0] = 8'h5A; pay[1] = 8'h81;
    burst("z1b", 2, 1'b0, 4, 6, 1, 8, -1, -1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("z1_after", IDLE_V);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
